// File: rtl/voice_allocator_pkg.sv
// Shared types and default widths for the voice allocator and the oscillator bank.
package synth_voice_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        APPLY = 2'd2
    } state_e;

    localparam int unsigned KEY_W           = 8;
    localparam int unsigned FREQ_W          = 16;
    localparam int unsigned AMP_W           = 31;
    localparam int unsigned AGE_W           = 8;
    localparam int unsigned CLOCK_FREQUENCY = 50_000_000;

endpackage

// File: rtl/voice_allocator_if.sv
// Note event valid/ready channel: the sequencer is master, the allocator is slave.
interface voice_allocator_if #(
    parameter int unsigned KEY_W  = synth_voice_pkg::KEY_W,
    parameter int unsigned FREQ_W = synth_voice_pkg::FREQ_W,
    parameter int unsigned AMP_W  = synth_voice_pkg::AMP_W
);
    logic              ev_valid;
    logic              ev_ready;
    logic              ev_note_on;
    logic [KEY_W-1:0]  ev_key;
    logic [FREQ_W-1:0] ev_freq;
    logic [AMP_W-1:0]  ev_amp;

    modport master (output ev_valid, ev_note_on, ev_key, ev_freq, ev_amp, input ev_ready);
    modport slave  (input ev_valid, ev_note_on, ev_key, ev_freq, ev_amp, output ev_ready);
endinterface

// File: rtl/voice_allocator_slot.sv
// One oscillator slot: key/freq/amp/active/age registers driven by load, clear and age strobes.
// The age output exists only when VOICE_ALLOC_STEAL_EN is defined.
module voice_slot #(
    parameter int unsigned KEY_W  = 8,
    parameter int unsigned FREQ_W = 16,
    parameter int unsigned AMP_W  = 31,
    parameter int unsigned AGE_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              clr_i,
    input  logic              age_inc_i,
    input  logic [KEY_W-1:0]  key_i,
    input  logic [FREQ_W-1:0] freq_i,
    input  logic [AMP_W-1:0]  amp_i,
    output logic [KEY_W-1:0]  key_o,
    output logic [FREQ_W-1:0] freq_o,
    output logic [AMP_W-1:0]  amp_o,
    output logic              active_o
`ifdef VOICE_ALLOC_STEAL_EN
   ,output logic [AGE_W-1:0]  age_o
`endif
);
    logic [KEY_W-1:0]  key_q;
    logic [FREQ_W-1:0] freq_q;
    logic [AMP_W-1:0]  amp_q;
    logic              active_q;
    logic [AGE_W-1:0]  age_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_q    <= '0;
            freq_q   <= '0;
            amp_q    <= '0;
            active_q <= 1'b0;
            age_q    <= '0;
        end else if (load_i) begin
            key_q    <= key_i;
            freq_q   <= freq_i;
            amp_q    <= amp_i;
            active_q <= 1'b1;
            age_q    <= '0;
        end else if (clr_i) begin
            key_q    <= '0;
            freq_q   <= '0;
            amp_q    <= '0;
            active_q <= 1'b0;
            age_q    <= '0;
        end else if (age_inc_i && (age_q != '1)) begin
            age_q <= age_q + 1'b1;
        end
    end

    assign key_o    = key_q;
    assign freq_o   = freq_q;
    assign amp_o    = amp_q;
    assign active_o = active_q;
`ifdef VOICE_ALLOC_STEAL_EN
    assign age_o    = age_q;
`endif
endmodule

// File: rtl/voice_allocator.sv
// Polyphony allocator: scans slots one per cycle, then retriggers, allocates, steals or drops.
// Define VOICE_ALLOC_STEAL_EN to steal the oldest slot instead of dropping when all are busy.
module voice_allocator #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned KEY_W      = synth_voice_pkg::KEY_W,
    parameter int unsigned FREQ_W     = synth_voice_pkg::FREQ_W,
    parameter int unsigned AMP_W      = synth_voice_pkg::AMP_W,
    parameter int unsigned AGE_W      = synth_voice_pkg::AGE_W
) (
    input  logic                         clk,
    input  logic                         reset,
    voice_allocator_if.slave             ev,
    output logic [NUM_VOICES*FREQ_W-1:0] voice_freq,
    output logic [NUM_VOICES*AMP_W-1:0]  voice_amp,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic                         drop
);
    import synth_voice_pkg::*;

    localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              on_q, on_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic [AMP_W-1:0]  amp_q, amp_d;
    logic              match_q, match_d;
    logic [IDX_W-1:0]  match_idx_q, match_idx_d;
    logic              free_q, free_d;
    logic [IDX_W-1:0]  free_idx_q, free_idx_d;
    logic              drop_q, drop_d;
    logic              ready;

    logic [NUM_VOICES-1:0] load, clr, inc;
    logic [KEY_W-1:0]      s_key [NUM_VOICES];
`ifdef VOICE_ALLOC_STEAL_EN
    logic [AGE_W-1:0]      s_age [NUM_VOICES];
    logic [IDX_W-1:0]      old_idx_q, old_idx_d;
    logic [AGE_W-1:0]      old_age_q, old_age_d;
`endif

    assign ready       = (state_q == IDLE) && !reset;
    assign ev.ev_ready = ready;
    assign drop        = drop_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        on_d        = on_q;
        key_d       = key_q;
        freq_d      = freq_q;
        amp_d       = amp_q;
        match_d     = match_q;
        match_idx_d = match_idx_q;
        free_d      = free_q;
        free_idx_d  = free_idx_q;
        drop_d      = 1'b0;
        load        = '0;
        clr         = '0;
        inc         = '0;
`ifdef VOICE_ALLOC_STEAL_EN
        old_idx_d   = old_idx_q;
        old_age_d   = old_age_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (ev.ev_valid && ready) begin
                    // A zero-frequency note-on is folded into a note-off here.
                    on_d    = ev.ev_note_on && (ev.ev_freq != '0);
                    key_d   = ev.ev_key;
                    freq_d  = ev.ev_freq;
                    amp_d   = ev.ev_amp;
                    match_d = 1'b0;
                    free_d  = 1'b0;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (voice_active[idx_q] && (s_key[idx_q] == key_q) && !match_q) begin
                    match_d     = 1'b1;
                    match_idx_d = idx_q;
                end
                if (!voice_active[idx_q] && !free_q) begin
                    free_d     = 1'b1;
                    free_idx_d = idx_q;
                end
`ifdef VOICE_ALLOC_STEAL_EN
                // Only consulted when every slot is active, so no active qualifier is needed.
                if ((idx_q == '0) || (s_age[idx_q] > old_age_q)) begin
                    old_idx_d = idx_q;
                    old_age_d = s_age[idx_q];
                end
`endif
                if (idx_q == LAST_IDX) state_d = APPLY;
                else                   idx_d   = idx_q + 1'b1;
            end
            APPLY: begin
                state_d = IDLE;
                if (on_q) begin
                    if (match_q)     load[match_idx_q] = 1'b1;
                    else if (free_q) load[free_idx_q]  = 1'b1;
                    else begin
`ifdef VOICE_ALLOC_STEAL_EN
                        load[old_idx_q] = 1'b1;
`else
                        drop_d = 1'b1;
`endif
                    end
                    if (|load) inc = voice_active & ~load;
                end else if (match_q) begin
                    clr[match_idx_q] = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            on_q        <= 1'b0;
            key_q       <= '0;
            freq_q      <= '0;
            amp_q       <= '0;
            match_q     <= 1'b0;
            match_idx_q <= '0;
            free_q      <= 1'b0;
            free_idx_q  <= '0;
            drop_q      <= 1'b0;
`ifdef VOICE_ALLOC_STEAL_EN
            old_idx_q   <= '0;
            old_age_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            on_q        <= on_d;
            key_q       <= key_d;
            freq_q      <= freq_d;
            amp_q       <= amp_d;
            match_q     <= match_d;
            match_idx_q <= match_idx_d;
            free_q      <= free_d;
            free_idx_q  <= free_idx_d;
            drop_q      <= drop_d;
`ifdef VOICE_ALLOC_STEAL_EN
            old_idx_q   <= old_idx_d;
            old_age_q   <= old_age_d;
`endif
        end
    end

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
        voice_slot #(
            .KEY_W (KEY_W),
            .FREQ_W(FREQ_W),
            .AMP_W (AMP_W),
            .AGE_W (AGE_W)
        ) u_slot (
            .clk      (clk),
            .reset    (reset),
            .load_i   (load[i]),
            .clr_i    (clr[i]),
            .age_inc_i(inc[i]),
            .key_i    (key_q),
            .freq_i   (freq_q),
            .amp_i    (amp_q),
            .key_o    (s_key[i]),
            .freq_o   (voice_freq[i*FREQ_W +: FREQ_W]),
            .amp_o    (voice_amp[i*AMP_W +: AMP_W]),
            .active_o (voice_active[i])
`ifdef VOICE_ALLOC_STEAL_EN
           ,.age_o    (s_age[i])
`endif
        );
    end
endmodule

// File: tb/tb_voice_allocator.sv
// Directed scoreboard bench for voice_allocator (NUM_VOICES = 4); honours VOICE_ALLOC_STEAL_EN.
module tb_voice_allocator;
    localparam int NV = 4;
    localparam int KW = 8;
    localparam int FW = 16;
    localparam int AW = 31;
    localparam int GW = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [NV*FW-1:0] voice_freq;
    logic [NV*AW-1:0] voice_amp;
    logic [NV-1:0]    voice_active;
    logic             drop;

    voice_allocator_if #(.KEY_W(KW), .FREQ_W(FW), .AMP_W(AW)) ev_if();

    voice_allocator #(
        .NUM_VOICES(NV), .KEY_W(KW), .FREQ_W(FW), .AMP_W(AW), .AGE_W(GW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ev          (ev_if),
        .voice_freq  (voice_freq),
        .voice_amp   (voice_amp),
        .voice_active(voice_active),
        .drop        (drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NV*FW-1:0] f;
        logic [NV*AW-1:0] a;
        logic [NV-1:0]    act;
        logic             d;
    } exp_t;

    exp_t sbq[$];

    logic          m_act [NV];
    logic [KW-1:0] m_key [NV];
    logic [FW-1:0] m_freq[NV];
    logic [AW-1:0] m_amp [NV];
    int            m_age [NV];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_act[i] = 1'b0; m_key[i] = '0; m_freq[i] = '0; m_amp[i] = '0; m_age[i] = 0;
        end
    endtask

    function automatic logic [NV-1:0] model_act();
        logic [NV-1:0] v;
        for (int i = 0; i < NV; i++) v[i] = m_act[i];
        return v;
    endfunction

    task automatic model_apply(input logic on, input logic [KW-1:0] k,
                               input logic [FW-1:0] f, input logic [AW-1:0] a);
        int mi, fi, oi, tgt;
        logic d;
        exp_t e;
        mi = -1; fi = -1; oi = -1; tgt = -1; d = 1'b0;
        for (int i = 0; i < NV; i++) begin
            if (m_act[i] && m_key[i] == k && mi < 0) mi = i;
            if (!m_act[i] && fi < 0) fi = i;
            if (m_act[i] && (oi < 0 || m_age[i] > m_age[oi])) oi = i;
        end
        if (on && f != '0) begin
            if (mi >= 0)      tgt = mi;
            else if (fi >= 0) tgt = fi;
            else begin
`ifdef VOICE_ALLOC_STEAL_EN
                tgt = oi;
`else
                d = 1'b1;
`endif
            end
            if (tgt >= 0) begin
                for (int i = 0; i < NV; i++)
                    if (i != tgt && m_act[i] && m_age[i] < 255) m_age[i]++;
                m_act[tgt] = 1'b1; m_key[tgt] = k; m_freq[tgt] = f; m_amp[tgt] = a; m_age[tgt] = 0;
            end
        end else if (mi >= 0) begin
            m_act[mi] = 1'b0; m_key[mi] = '0; m_freq[mi] = '0; m_amp[mi] = '0; m_age[mi] = 0;
        end
        for (int i = 0; i < NV; i++) begin
            e.f[i*FW +: FW] = m_freq[i];
            e.a[i*AW +: AW] = m_amp[i];
            e.act[i]        = m_act[i];
        end
        e.d = d;
        sbq.push_back(e);
    endtask

    task automatic send(input logic on, input logic [KW-1:0] k, input logic [FW-1:0] f,
                        input logic [AW-1:0] a, input string tag);
        logic [NV-1:0] prev;
        exp_t e;
        int n;
        prev = model_act();
        model_apply(on, k, f, a);
        @(negedge clk);
        ev_if.ev_valid = 1'b1; ev_if.ev_note_on = on; ev_if.ev_key = k;
        ev_if.ev_freq = f; ev_if.ev_amp = a;
        n = 0;
        while (!ev_if.ev_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++; errors++;
            $error("FAIL %s ready timeout: observed 0 expected 1", tag);
            ev_if.ev_valid = 1'b0;
            void'(sbq.pop_front());
            return;
        end
        @(posedge clk); #1;
        // Scribble the fields: the allocator must have sampled them at the handshake.
        ev_if.ev_valid = 1'b0; ev_if.ev_note_on = ~on; ev_if.ev_key = 8'hEE;
        ev_if.ev_freq = 16'h1234; ev_if.ev_amp = '1;
        for (int c = 0; c <= NV; c++) begin
            check({tag, " ready low"}, 128'(ev_if.ev_ready), 128'(1'b0));
            check({tag, " hold"}, 128'(voice_active), 128'(prev));
            @(posedge clk); #1;
        end
        e = sbq.pop_front();
        check({tag, " freq"},   128'(voice_freq),   128'(e.f));
        check({tag, " amp"},    128'(voice_amp),    128'(e.a));
        check({tag, " active"}, 128'(voice_active), 128'(e.act));
        check({tag, " drop"},   128'(drop),         128'(e.d));
        check({tag, " ready back"}, 128'(ev_if.ev_ready), 128'(1'b1));
        @(posedge clk); #1;
        check({tag, " drop end"}, 128'(drop), 128'(1'b0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " freq"},   128'(voice_freq),   128'(0));
        check({tag, " amp"},    128'(voice_amp),    128'(0));
        check({tag, " active"}, 128'(voice_active), 128'(0));
        check({tag, " drop"},   128'(drop),         128'(0));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check({tag, " ready"}, 128'(ev_if.ev_ready), 128'(1'b0));
        check_all_zero(tag);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        check({tag, " ready after"}, 128'(ev_if.ev_ready), 128'(1'b1));
    endtask

    initial begin
        logic [FW-1:0] f0;
        ev_if.ev_valid = 1'b0; ev_if.ev_note_on = 1'b0; ev_if.ev_key = '0;
        ev_if.ev_freq = '0; ev_if.ev_amp = '0;
        model_reset();

        do_reset("reset");

        send(1'b1, 8'd60, 16'd440, 31'd1000, "first on");
        f0 = voice_freq[FW-1:0];
        check("slot0 freq 440", 128'(f0), 128'(16'd440));

        send(1'b1, 8'd62, 16'd494, 31'd900, "on 62");
        send(1'b1, 8'd64, 16'd523, 31'd800, "on 64");
        send(1'b1, 8'd65, 16'd587, 31'd700, "on 65");
        send(1'b0, 8'd62, 16'd0,   31'd0,   "off 62");
        check("off 62 active", 128'(voice_active), 128'(4'b1101));
        send(1'b1, 8'd67, 16'd659, 31'd600, "on 67 reuse");

        send(1'b1, 8'd60, 16'd440, 31'd500, "retrigger 60");
        send(1'b0, 8'd99, 16'd0,   31'd0,   "off unheld 99");
        send(1'b1, 8'd64, 16'd0,   31'd123, "zero-freq 64");

        // Reset while the allocator is scanning: the in-flight event must vanish.
        do_reset("reset2");
        send(1'b1, 8'd20, 16'd200, 31'd20, "on 20");
        send(1'b1, 8'd21, 16'd210, 31'd21, "on 21");
        @(negedge clk);
        ev_if.ev_valid = 1'b1; ev_if.ev_note_on = 1'b1; ev_if.ev_key = 8'd22;
        ev_if.ev_freq = 16'd220; ev_if.ev_amp = 31'd22;
        check("midscan ready before", 128'(ev_if.ev_ready), 128'(1'b1));
        @(posedge clk); #1;
        ev_if.ev_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("midscan ready", 128'(ev_if.ev_ready), 128'(1'b0));
        check_all_zero("midscan");
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        check("midscan ready after", 128'(ev_if.ev_ready), 128'(1'b1));
        repeat (NV + 3) @(posedge clk);
        #1;
        check_all_zero("midscan lost");

        send(1'b1, 8'd10, 16'd100, 31'd10, "fill 10");
        send(1'b1, 8'd11, 16'd110, 31'd11, "fill 11");
        send(1'b1, 8'd12, 16'd120, 31'd12, "fill 12");
        send(1'b1, 8'd13, 16'd130, 31'd13, "fill 13");
        send(1'b1, 8'd70, 16'd700, 31'd70, "full on 70");
        f0 = voice_freq[FW-1:0];
`ifdef VOICE_ALLOC_STEAL_EN
        check("steal slot0", 128'(f0), 128'(16'd700));
`else
        check("no steal slot0", 128'(f0), 128'(16'd100));
`endif
        send(1'b1, 8'd71, 16'd710, 31'd71, "full on 71");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
